// File: rtl/route_cmd_cntrl_pkg.sv
// Shared types for the route command controller: command opcodes and FSM states.
package route_pkg;

  typedef enum logic [1:0] {
    OP_STOP   = 2'b00,
    OP_GO     = 2'b01,
    OP_APPEND = 2'b10,
    OP_RSVD   = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DWELL
  } state_t;

endpackage

// File: rtl/route_cmd_cntrl_if.sv
// Handshake/status bundle between the command/ID sources, motion control and the route controller.
interface route_cmd_cntrl_if #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 4
);
    logic [ID_W+1:0]         cmd;
    logic                    cmd_rdy;
    logic                    clr_cmd_rdy;
    logic [ID_W-1:0]         ID;
    logic                    ID_vld;
    logic                    clr_ID_vld;
    logic                    OK2Move;
    logic                    in_transit;
    logic                    go;
    logic                    arrived;
    logic                    cmd_err;
    logic [$clog2(DEPTH):0]  q_cnt;
    logic                    buzz;
    logic                    buzz_n;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld, OK2Move,
        input  clr_cmd_rdy, clr_ID_vld, in_transit, go, arrived, cmd_err, q_cnt, buzz, buzz_n
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
        output clr_cmd_rdy, clr_ID_vld, in_transit, go, arrived, cmd_err, q_cnt, buzz, buzz_n
    );
endinterface

// File: rtl/route_cmd_cntrl_dest_fifo.sv
// Destination-ID queue: synchronous push/pop/flush; push+pop when full is legal (pop first).
module dest_fifo #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ID_W-1:0]        din,
    output logic [ID_W-1:0]        head,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_addr;
    logic             do_pop, do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A flush empties the queue first, so a simultaneous push always lands in slot 0.
    assign do_push = push & (flush | ~full | do_pop);
    assign wr_addr = flush ? '0 : wr_ptr;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity, which keeps it RAM-inferable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_addr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PTR_W'(1) : '0;
            cnt    <= do_push ? (PTR_W+1)'(1) : '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
endmodule

// File: rtl/route_cmd_cntrl.sv
// Route command/control FSM: destination queue, station dwell, obstacle buzzer.
// Optional obstacle abort timeout enabled by defining ABORT_TIMEOUT_EN.
module route_cmd_cntrl
    import route_pkg::*;
#(
    parameter int ID_W        = 6,
    parameter int DEPTH       = 4,
    parameter int DWELL_CYC   = 50000,
    parameter int BUZZ_PERIOD = 12500,
    parameter int OBST_TMO    = 2**20
) (
    input  logic          clk,
    input  logic          rst_n,
    route_cmd_cntrl_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DW_W  = $clog2(DWELL_CYC + 1);
    localparam int BZ_W  = $clog2(BUZZ_PERIOD);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DWELL_CYC < 1 ||
        BUZZ_PERIOD < 4 || (BUZZ_PERIOD % 2) != 0 || OBST_TMO < 1) begin : g_bad_param
        $error("route_cmd_cntrl: illegal parameter set");
    end

    state_t           state, state_nxt;
    opcode_t          op;
    logic [ID_W-1:0]  dest, head;
    logic [CNT_W-1:0] q_cnt;
    logic             full, empty;
    logic             fifo_flush, fifo_push, fifo_pop;
    logic             id_match, dwell_done, abort;
    logic             arrived_nxt, err_nxt;
    logic             in_transit_q, arrived_q, cmd_err_q;
    logic [DW_W-1:0]  dwell_cnt;
    logic [BZ_W-1:0]  buzz_cnt;
    logic             buzz_en;

    assign op   = opcode_t'(bus.cmd[ID_W+1:ID_W]);
    assign dest = bus.cmd[ID_W-1:0];

    assign id_match   = (state == MOVE) && bus.ID_vld && !empty && (bus.ID == head);
    assign dwell_done = (state == DWELL) && (dwell_cnt == DW_W'(DWELL_CYC - 1));

    dest_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dest),
        .head  (head),
        .cnt   (q_cnt),
        .full  (full),
        .empty (empty)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        fifo_flush  = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        arrived_nxt = 1'b0;
        err_nxt     = 1'b0;
        if (bus.cmd_rdy && op == OP_STOP) begin
            fifo_flush = 1'b1;
            state_nxt  = IDLE;
        end else if (bus.cmd_rdy && op == OP_GO) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b1;
            state_nxt  = MOVE;
        end else if (abort) begin
            fifo_flush = 1'b1;
            err_nxt    = 1'b1;
            state_nxt  = IDLE;
        end else begin
            fifo_pop = id_match;
            if (bus.cmd_rdy && op == OP_APPEND) begin
                if (!full || id_match) fifo_push = 1'b1;
                else                   err_nxt   = 1'b1;
            end
            if (bus.cmd_rdy && op == OP_RSVD) err_nxt = 1'b1;
            // A same-cycle append keeps the queue non-empty, so it is a dwell, not an arrival.
            if (id_match) begin
                if (q_cnt == CNT_W'(1) && !fifo_push) begin
                    state_nxt   = IDLE;
                    arrived_nxt = 1'b1;
                end else begin
                    state_nxt = DWELL;
                end
            end else if (state == IDLE && fifo_push) begin
                state_nxt = MOVE;
            end else if (dwell_done) begin
                state_nxt = MOVE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_transit_q <= 1'b0;
            arrived_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
            dwell_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            in_transit_q <= (state_nxt == MOVE);
            arrived_q    <= arrived_nxt;
            cmd_err_q    <= err_nxt;
            dwell_cnt    <= (state == DWELL && state_nxt == DWELL) ? dwell_cnt + DW_W'(1) : '0;
        end
    end

`ifdef ABORT_TIMEOUT_EN
    localparam int OT_W = $clog2(OBST_TMO + 1);
    logic [OT_W-1:0] obst_cnt;
    logic            obst_blocked;

    assign obst_blocked = (state == MOVE) && !bus.OK2Move;
    assign abort        = obst_blocked && (obst_cnt == OT_W'(OBST_TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      obst_cnt <= '0;
        else if (obst_blocked && !abort) obst_cnt <= obst_cnt + OT_W'(1);
        else                             obst_cnt <= '0;
    end
`else
    assign abort = 1'b0;
`endif

    // Buzzer square wave runs only while commanded to move but blocked.
    assign buzz_en = in_transit_q & ~bus.OK2Move;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   buzz_cnt <= '0;
        else if (!buzz_en)                            buzz_cnt <= '0;
        else if (buzz_cnt == BZ_W'(BUZZ_PERIOD - 1))  buzz_cnt <= '0;
        else                                          buzz_cnt <= buzz_cnt + BZ_W'(1);
    end

    assign bus.buzz        = buzz_en && (buzz_cnt < BZ_W'(BUZZ_PERIOD / 2));
    assign bus.buzz_n      = ~bus.buzz;
    assign bus.clr_cmd_rdy = bus.cmd_rdy;
    assign bus.clr_ID_vld  = bus.ID_vld;
    assign bus.in_transit  = in_transit_q;
    assign bus.go          = in_transit_q & bus.OK2Move;
    assign bus.arrived     = arrived_q;
    assign bus.cmd_err     = cmd_err_q;
    assign bus.q_cnt       = q_cnt;
endmodule
